// File: rtl/buttons_pkg.sv
// Shared constants, helper functions and hold-tracker state type for the
// button event controller. Optional feature macro: BUTTONS_AUTOREPEAT_EN.
package buttons_pkg;

  // Default tick counts for a 50 MHz board clock.
  localparam int unsigned DEFAULT_DEBOUNCING_TICKS = 4;
  localparam int unsigned DEFAULT_HOLD_TICKS       = 50_000_000;
  localparam int unsigned DEFAULT_REPEAT_TICKS     = 10_000_000;

  typedef enum logic [1:0] {
    HOLD_IDLE,
    HOLD_COUNT,
    HOLD_DONE,
    HOLD_REPEAT
  } hold_state_e;

  // Ceiling log2, never less than 1 so derived counters keep a legal width.
  function automatic int unsigned clog2(input longint unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      if ((64'd1 << i) < value) result = i + 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: two-flop synchroniser, debouncer, press/release pulses
// and hold detection. Optional feature macro: BUTTONS_AUTOREPEAT_EN.
module button_channel
  import buttons_pkg::*;
#(
  parameter int unsigned DEBOUNCING_TICKS = DEFAULT_DEBOUNCING_TICKS,
  parameter int unsigned HOLD_TICKS       = DEFAULT_HOLD_TICKS,
  parameter int unsigned REPEAT_TICKS     = DEFAULT_REPEAT_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o
);

  localparam int unsigned CW = clog2(longint'(DEBOUNCING_TICKS) + 1);
  localparam int unsigned HW = clog2(longint'(max_u(HOLD_TICKS, REPEAT_TICKS)) + 1);

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCING_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
`ifdef BUTTONS_AUTOREPEAT_EN
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_TICKS - 1);
`else
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_TICKS);
`endif

  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  logic [HW-1:0] hcnt_q;
  logic          hold_q;
  hold_state_e   hstate_q;

  // Any sample matching the current level restarts the debounce count.
  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (s2_q != level_q) begin
      if (cnt_q == DB_LAST) begin
        level_d   = s2_q;
        cnt_d     = '0;
        press_d   = s2_q;
        release_d = ~s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= raw_i;
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Hold tracker: counts edges while the debounced level is high; the first
  // counted edge after a press sees hcnt_q == 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hstate_q <= HOLD_IDLE;
      hcnt_q   <= '0;
      hold_q   <= 1'b0;
    end else begin
      hold_q <= 1'b0;
      if (!level_q) begin
        hstate_q <= HOLD_IDLE;
        hcnt_q   <= '0;
      end else begin
        case (hstate_q)
          HOLD_IDLE, HOLD_COUNT: begin
            if (hcnt_q == HOLD_LAST) begin
              hold_q <= 1'b1;
`ifdef BUTTONS_AUTOREPEAT_EN
              hstate_q <= HOLD_REPEAT;
              hcnt_q   <= '0;
`else
              hstate_q <= HOLD_DONE;
              hcnt_q   <= HOLD_SAT;
`endif
            end else begin
              hstate_q <= HOLD_COUNT;
              hcnt_q   <= hcnt_q + 1'b1;
            end
          end
`ifdef BUTTONS_AUTOREPEAT_EN
          HOLD_REPEAT: begin
            if (hcnt_q == REP_LAST) begin
              hold_q <= 1'b1;
              hcnt_q <= '0;
            end else begin
              hcnt_q <= hcnt_q + 1'b1;
            end
          end
`endif
          default: begin
            hstate_q <= hstate_q;
            hcnt_q   <= hcnt_q;
          end
        endcase
      end
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign hold_o    = hold_q;

endmodule

// File: rtl/buttons_event_controller.sv
// N-channel button front end with sticky pending-press register and per-bit
// acknowledge. Optional feature macro: BUTTONS_AUTOREPEAT_EN.
module buttons_event_controller
  import buttons_pkg::*;
#(
  parameter int unsigned CHANNELS         = 5,
  parameter int unsigned DEBOUNCING_TICKS = DEFAULT_DEBOUNCING_TICKS,
  parameter int unsigned HOLD_TICKS       = DEFAULT_HOLD_TICKS,
  parameter int unsigned REPEAT_TICKS     = DEFAULT_REPEAT_TICKS,
  parameter bit          ACTIVE_LOW       = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] button_pins_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] press_o,
  output logic [CHANNELS-1:0] release_o,
  output logic [CHANNELS-1:0] hold_o,
  output logic [CHANNELS-1:0] pending_o,
  input  logic [CHANNELS-1:0] ack_i
);

  logic [CHANNELS-1:0] raw;
  logic [CHANNELS-1:0] pending_q, pending_d;

  assign raw = ACTIVE_LOW ? ~button_pins_i : button_pins_i;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    button_channel #(
      .DEBOUNCING_TICKS(DEBOUNCING_TICKS),
      .HOLD_TICKS      (HOLD_TICKS),
      .REPEAT_TICKS    (REPEAT_TICKS)
    ) u_channel (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (raw[i]),
      .level_o  (level_o[i]),
      .press_o  (press_o[i]),
      .release_o(release_o[i]),
      .hold_o   (hold_o[i])
    );
  end

  // A new event on the same bit as an ack wins, so no press is ever lost.
  always_comb begin
    pending_d = (pending_q & ~ack_i) | press_o;
`ifdef BUTTONS_AUTOREPEAT_EN
    pending_d = pending_d | hold_o;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign pending_o = pending_q;

endmodule

// File: tb/tb_buttons_event_controller.sv
// Randomised scoreboard bench for buttons_event_controller against a
// history-based reference model (honours BUTTONS_AUTOREPEAT_EN).
module tb_buttons_event_controller;

  localparam int CH = 5;
  localparam int DT = 4;
  localparam int HT = 10;
  localparam int RT = 4;

  typedef struct packed {
    logic [CH-1:0] level;
    logic [CH-1:0] press;
    logic [CH-1:0] rel;
    logic [CH-1:0] hold;
    logic [CH-1:0] pend;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [CH-1:0] button_pins;
  logic [CH-1:0] ack;
  logic [CH-1:0] level, press, rel, hold, pending;

  int checks;
  int failures;
  int cycle;

  exp_t sbq[$];
  exp_t mon_e;

  // Reference model state: per-edge history of pressed values since reset.
  bit [CH-1:0] hist[$];
  bit [CH-1:0] m_lvl, m_prs, m_rel, m_hld, m_pnd;
  int          m_last_flip[CH];
  int          m_press_edge[CH];

  buttons_event_controller #(
    .CHANNELS        (CH),
    .DEBOUNCING_TICKS(DT),
    .HOLD_TICKS      (HT),
    .REPEAT_TICKS    (RT),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .button_pins_i(button_pins),
    .level_o      (level),
    .press_o      (press),
    .release_o    (rel),
    .hold_o       (hold),
    .pending_o    (pending),
    .ack_i        (ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Pressed value the debouncer evaluates at edge k (two-flop delay, reset = released).
  function automatic bit samp(input int k, input int c);
    bit [CH-1:0] v;
    if (k < 3) return 1'b0;
    v = hist[k-3];
    return v[c];
  endfunction

  task automatic model_edge(input bit r, input logic [CH-1:0] prs, input logic [CH-1:0] a);
    exp_t        e;
    bit [CH-1:0] nl, np, nr, nh, npd;
    int          k, d;
    bit          lv, flip;
    if (r) begin
      hist.delete();
      m_lvl = '0; m_prs = '0; m_rel = '0; m_hld = '0; m_pnd = '0;
      for (int c = 0; c < CH; c++) begin
        m_last_flip[c]  = 0;
        m_press_edge[c] = 0;
      end
      sbq.push_back('0);
      return;
    end
    hist.push_back(prs);
    k   = hist.size();
    npd = (m_pnd & ~a) | m_prs;
`ifdef BUTTONS_AUTOREPEAT_EN
    npd = npd | m_hld;
`endif
    for (int c = 0; c < CH; c++) begin
      lv    = m_lvl[c];
      d     = k - m_press_edge[c];
`ifdef BUTTONS_AUTOREPEAT_EN
      nh[c] = lv && (d == HT || (d > HT && ((d - HT) % RT) == 0));
`else
      nh[c] = lv && (d == HT);
`endif
      // Level flips once the last DT evaluated samples since the previous flip all differ.
      flip = (k - m_last_flip[c]) >= DT;
      for (int m = k - DT + 1; m <= k; m++)
        if (flip && samp(m, c) == lv) flip = 1'b0;
      nl[c] = lv ^ flip;
      np[c] = flip && !lv;
      nr[c] = flip && lv;
      if (flip) begin
        m_last_flip[c] = k;
        if (!lv) m_press_edge[c] = k;
      end
    end
    m_lvl = nl; m_prs = np; m_rel = nr; m_hld = nh; m_pnd = npd;
    e.level = nl; e.press = np; e.rel = nr; e.hold = nh; e.pend = npd;
    sbq.push_back(e);
  endtask

  task automatic step(input bit r, input logic [CH-1:0] prs, input logic [CH-1:0] a);
    @(negedge clk);
    rst         = r;
    button_pins = ~prs;
    ack         = a;
    model_edge(r, prs, a);
  endtask

  task automatic run(input int n, input bit r, input logic [CH-1:0] prs, input logic [CH-1:0] a);
    for (int i = 0; i < n; i++) step(r, prs, a);
  endtask

  task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%b required=%b", name, cycle, act, req);
    end
  endtask

  // Monitor: compares every registered output set against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (sbq.size() != 0) begin
      mon_e = sbq.pop_front();
      chk("level",   level,   mon_e.level);
      chk("press",   press,   mon_e.press);
      chk("release", rel,     mon_e.rel);
      chk("hold",    hold,    mon_e.hold);
      chk("pending", pending, mon_e.pend);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cycle);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [CH-1:0] cur, a;
    int            pct;
    checks      = 0;
    failures    = 0;
    cycle       = 0;
    rst         = 1'b1;
    button_pins = '0;
    ack         = '0;

    // Reset with every button pressed, then a long press with hold and release.
    run(3, 1'b1, '1, '0);
    run(30, 1'b0, '1, '0);
    run(12, 1'b0, '0, '0);
    // Bounce on ch1: 3 active, 1 inactive, then steady.
    run(3, 1'b0, 5'b00010, '0);
    run(1, 1'b0, 5'b00000, '0);
    run(14, 1'b0, 5'b00010, '0);
    run(10, 1'b0, 5'b00000, '0);
    // Short press on ch2: released 8 cycles after the debounce completes.
    run(DT + 2 + 8, 1'b0, 5'b00100, '0);
    run(10, 1'b0, 5'b00000, '0);
    // pending/ack on ch0 and ch3, then ack held across a fresh ch0 press.
    run(8, 1'b0, 5'b01001, '0);
    run(10, 1'b0, 5'b00000, '0);
    run(1, 1'b0, 5'b00000, 5'b00001);
    run(3, 1'b0, 5'b00000, '0);
    run(12, 1'b0, 5'b00001, 5'b00001);
    run(10, 1'b0, 5'b00000, 5'b01000);
    // Reset while buttons are held, then a fresh press after release.
    run(8, 1'b0, 5'b10101, '0);
    run(2, 1'b1, 5'b10101, '0);
    run(12, 1'b0, 5'b10101, '0);
    run(8, 1'b0, 5'b00000, '0);

    // Random phase: bouncy at first, then slow enough for holds/repeats.
    cur = '0;
    for (int i = 0; i < 2000; i++) begin
      pct = (i < 600) ? 20 : 2;
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 99) < pct) cur[c] = ~cur[c];
        a[c] = ($urandom_range(0, 5) == 0);
      end
      step(1'b0, cur, a);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
